// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: I2S / left-justified / TDM serial audio transmitter.
// Bit clock is divided down from clk; one frame of samples is accepted per
// handshake into a single holding register and copied to the shifter at the
// start of every frame.
module i2s_tx_multi #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned BCK_HALF = 2,
  parameter int unsigned MODE     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       bck,
  output logic                       ws,
  output logic                       sd,
  output logic                       frame_start,
  output logic                       underrun
);

  localparam int unsigned Frame     = CHANNELS * SLOT_W;
  localparam int unsigned FrameBits = CHANNELS * DATA_W;
  localparam int unsigned BcW       = $clog2(Frame);
  localparam int unsigned HcW       = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int unsigned IdxW      = $clog2(FrameBits);

  localparam logic [BcW-1:0] BcLast  = BcW'(Frame - 1);
  localparam logic [HcW-1:0] HcLast  = HcW'(BCK_HALF - 1);
  // TDM frame sync in I2S mode sits on the last bit, which is where bc resets.
  localparam logic           WsReset = (CHANNELS > 2) && (MODE == 1);

  logic [HcW-1:0]       hc_q;
  logic [BcW-1:0]       bc_q, bc_d;
  logic                 bck_q, ws_q, ws_d, sd_q;
  logic                 frame_start_q, underrun_q, full_q;
  logic [FrameBits-1:0] hold_q, shift_q, shift_d;
  logic                 hc_end, tick, load, lj_new, lj_old;

  // Left-justified bit for bit position b of frame f (zero padding past DATA_W).
  function automatic logic lj_bit(input logic [BcW-1:0] b, input logic [FrameBits-1:0] f);
    int unsigned     pos, slot, p;
    logic [IdxW-1:0] idx;
    pos  = 32'(b);
    slot = pos / SLOT_W;
    p    = pos % SLOT_W;
    idx  = IdxW'(slot * DATA_W + DATA_W - 1 - p);
    lj_bit = (p < DATA_W) ? f[idx] : 1'b0;
  endfunction

  // Odd slots are the right channel in stereo framing.
  function automatic logic slot_odd(input logic [BcW-1:0] b);
    slot_odd = ((32'(b) / SLOT_W) % 2) == 1;
  endfunction

  // Divider decode and the state the serial outputs take on the next tick.
  always_comb begin
    hc_end  = (hc_q == HcLast);
    tick    = hc_end && bck_q;
    load    = tick && (bc_q == BcLast);
    bc_d    = load ? '0 : bc_q + 1'b1;
    shift_d = shift_q;
    if (load) begin
      shift_d = full_q ? hold_q : '0;
    end
    lj_new = lj_bit(bc_d, shift_d);
    // Bit being shown now; becomes the I2S output one tick later.
    lj_old = lj_bit(bc_q, shift_q);
    if (CHANNELS == 2) begin
      ws_d = slot_odd(bc_d);
    end else if (MODE == 0) begin
      ws_d = (bc_d == '0);
    end else begin
      ws_d = (bc_d == BcLast);
    end
  end

  // Divider, bit counter, serial outputs, holding register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      bc_q          <= BcLast;
      bck_q         <= 1'b0;
      ws_q          <= WsReset;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      full_q        <= 1'b0;
      hold_q        <= '0;
      shift_q       <= '0;
    end else begin
      frame_start_q <= load;
      underrun_q    <= load && !full_q;
      hc_q          <= hc_end ? '0 : hc_q + 1'b1;
      if (hc_end) begin
        bck_q <= !bck_q;
      end
      if (tick) begin
        bc_q    <= bc_d;
        shift_q <= shift_d;
        sd_q    <= (MODE == 0) ? lj_new : lj_old;
        ws_q    <= ws_d;
      end
      // A load only clears a full register and a write only fills an empty
      // one, so the two never collide; a write on the load edge waits a frame.
      if (load && full_q) begin
        full_q <= 1'b0;
      end else if (s_valid && !full_q) begin
        full_q <= 1'b1;
        hold_q <= s_data;
      end
    end
  end

  assign s_ready     = !full_q;
  assign bck         = bck_q;
  assign ws          = ws_q;
  assign sd          = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Directed bench for i2s_tx_multi: left-justified stereo, I2S stereo and
// 4-slot TDM instances share clk/rst, so their bit ticks coincide.
module tb_i2s_tx_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [47:0] s_data_st;
  logic        s_valid_st;
  logic [95:0] s_data_tdm;
  logic        s_valid_tdm;

  logic ready_lj, bck_lj, ws_lj, sd_lj, fs_lj, ur_lj;
  logic ready_i2s, bck_i2s, ws_i2s, sd_i2s, fs_i2s, ur_i2s;
  logic ready_tdm, bck_tdm, ws_tdm, sd_tdm, fs_tdm, ur_tdm;

  i2s_tx_multi #(.DATA_W(24), .SLOT_W(32), .CHANNELS(2), .BCK_HALF(2), .MODE(0)) u_lj (
    .clk(clk), .rst(rst), .s_data(s_data_st), .s_valid(s_valid_st), .s_ready(ready_lj),
    .bck(bck_lj), .ws(ws_lj), .sd(sd_lj), .frame_start(fs_lj), .underrun(ur_lj)
  );

  i2s_tx_multi #(.DATA_W(24), .SLOT_W(32), .CHANNELS(2), .BCK_HALF(2), .MODE(1)) u_i2s (
    .clk(clk), .rst(rst), .s_data(s_data_st), .s_valid(s_valid_st), .s_ready(ready_i2s),
    .bck(bck_i2s), .ws(ws_i2s), .sd(sd_i2s), .frame_start(fs_i2s), .underrun(ur_i2s)
  );

  i2s_tx_multi #(.DATA_W(24), .SLOT_W(32), .CHANNELS(4), .BCK_HALF(2), .MODE(0)) u_tdm (
    .clk(clk), .rst(rst), .s_data(s_data_tdm), .s_valid(s_valid_tdm), .s_ready(ready_tdm),
    .bck(bck_tdm), .ws(ws_tdm), .sd(sd_tdm), .frame_start(fs_tdm), .underrun(ur_tdm)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int first_wait, last_wait;
  int period_bad = 0;
  int stable_bad = 0;
  int rdy_bad    = 0;
  int pay        = 0;
  bit st_stream  = 1'b0;

  // Per-tick captures, first captured bit ends up most significant.
  logic [255:0] v_sd_lj, v_sd_i2s, v_sd_tdm, v_ws_lj, v_ws_i2s, v_ws_tdm;
  logic [255:0] v_fs_lj, v_ur_lj, v_fs_i2s, v_ur_i2s, v_fs_tdm, v_ur_tdm;
  logic [255:0] e3, e2;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] st_word(input int j);
    logic [23:0] l, r;
    l = 24'hA00000 | 24'(j);
    r = 24'h500000 | 24'(j);
    return {r, l};
  endfunction

  function automatic logic [63:0] st_frame(input int j);
    logic [23:0] l, r;
    l = 24'hA00000 | 24'(j);
    r = 24'h500000 | 24'(j);
    return {l, 8'h00, r, 8'h00};
  endfunction

  // One clk; also plays the source side of the handshake.
  task automatic step();
    logic xs, xt;
    xs = !rst && s_valid_st && ready_lj;
    xt = !rst && s_valid_tdm && ready_tdm;
    @(posedge clk);
    #1;
    if (xs) begin
      if (ready_lj !== 1'b0 || ready_i2s !== 1'b0) rdy_bad++;
      if (st_stream) begin
        pay++;
        s_data_st = st_word(pay);
      end else begin
        s_valid_st = 1'b0;
      end
    end
    if (xt) begin
      if (ready_tdm !== 1'b0) rdy_bad++;
      s_valid_tdm = 1'b0;
    end
  endtask

  task automatic next_tick();
    logic       last;
    logic [5:0] prev;
    bit         done;
    int         n;
    done = 1'b0;
    n    = 0;
    while (!done && n < 16) begin
      n++;
      last = bck_lj;
      prev = {sd_lj, ws_lj, sd_i2s, ws_i2s, sd_tdm, ws_tdm};
      step();
      if (last === 1'b1 && bck_lj === 1'b0) begin
        done = 1'b1;
      end else if ({sd_lj, ws_lj, sd_i2s, ws_i2s, sd_tdm, ws_tdm} !== prev) begin
        stable_bad++;
      end
    end
    last_wait = n;
    if (n != 4) period_bad++;
    if (!done) check("tick_timeout", 256'(n), 256'(4));
  endtask

  task automatic collect(input int n);
    v_sd_lj = '0; v_sd_i2s = '0; v_sd_tdm = '0;
    v_ws_lj = '0; v_ws_i2s = '0; v_ws_tdm = '0;
    v_fs_lj = '0; v_ur_lj = '0; v_fs_i2s = '0; v_ur_i2s = '0;
    v_fs_tdm = '0; v_ur_tdm = '0;
    for (int k = 0; k < n; k++) begin
      next_tick();
      if (k == 0) first_wait = last_wait;
      v_sd_lj  = {v_sd_lj[254:0], sd_lj};
      v_sd_i2s = {v_sd_i2s[254:0], sd_i2s};
      v_sd_tdm = {v_sd_tdm[254:0], sd_tdm};
      v_ws_lj  = {v_ws_lj[254:0], ws_lj};
      v_ws_i2s = {v_ws_i2s[254:0], ws_i2s};
      v_ws_tdm = {v_ws_tdm[254:0], ws_tdm};
      v_fs_lj  = {v_fs_lj[254:0], fs_lj};
      v_ur_lj  = {v_ur_lj[254:0], ur_lj};
      v_fs_i2s = {v_fs_i2s[254:0], fs_i2s};
      v_ur_i2s = {v_ur_i2s[254:0], ur_i2s};
      v_fs_tdm = {v_fs_tdm[254:0], fs_tdm};
      v_ur_tdm = {v_ur_tdm[254:0], ur_tdm};
      // After loading a full register the source must see room again.
      if (fs_lj === 1'b1 && ur_lj === 1'b0 && ready_lj !== 1'b1) rdy_bad++;
      if (fs_tdm === 1'b1 && ur_tdm === 1'b0 && ready_tdm !== 1'b1) rdy_bad++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_lj"},  256'({bck_lj, ws_lj, sd_lj, ready_lj, fs_lj, ur_lj}), 256'(6'b000100));
    check({tag, "_i2s"}, 256'({bck_i2s, ws_i2s, sd_i2s, ready_i2s, fs_i2s, ur_i2s}),
          256'(6'b000100));
    check({tag, "_tdm"}, 256'({bck_tdm, ws_tdm, sd_tdm, ready_tdm, fs_tdm, ur_tdm}),
          256'(6'b000100));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    s_data_st   = '0;
    s_valid_st  = 1'b0;
    s_data_tdm  = '0;
    s_valid_tdm = 1'b0;
    repeat (3) step();
    check_reset("reset_init");

    // One frame per DUT offered right at release, then nothing.
    rst         = 1'b0;
    s_data_st   = {24'h7FFFFE, 24'h800001};
    s_valid_st  = 1'b1;
    s_data_tdm  = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    s_valid_tdm = 1'b1;
    collect(128);
    check("first_tick_lat", 256'(first_wait), 256'(4));
    check("lj_sd",   v_sd_lj,  256'({64'h800001007FFFFE00, 64'h0}));
    check("i2s_sd",  v_sd_i2s, 256'({64'h400000803FFFFF00, 64'h0}));
    check("lj_ws",   v_ws_lj,  256'({64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF}));
    check("i2s_ws",  v_ws_i2s, 256'({64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF}));
    check("lj_fs",   v_fs_lj,  256'({64'h8000000000000000, 64'h8000000000000000}));
    check("lj_ur",   v_ur_lj,  256'({64'h0, 64'h8000000000000000}));
    check("i2s_fs",  v_fs_i2s, 256'({64'h8000000000000000, 64'h8000000000000000}));
    check("i2s_ur",  v_ur_i2s, 256'({64'h0, 64'h8000000000000000}));
    check("tdm_sd",  v_sd_tdm, 256'(128'h11111100_22222200_33333300_44444400));
    check("tdm_ws",  v_ws_tdm, 256'({1'b1, 127'b0}));
    check("tdm_fs",  v_fs_tdm, 256'({1'b1, 127'b0}));
    check("tdm_ur",  v_ur_tdm, 256'(0));

    // Three stereo frames with no source data.
    collect(192);
    e3 = '0; e3[191] = 1'b1; e3[127] = 1'b1; e3[63] = 1'b1;
    e2 = '0; e2[191] = 1'b1; e2[63] = 1'b1;
    check("udr_sd_lj",  v_sd_lj,  256'(0));
    check("udr_sd_i2s", v_sd_i2s, 256'(0));
    check("udr_sd_tdm", v_sd_tdm, 256'(0));
    check("udr_fs_lj",  v_fs_lj,  e3);
    check("udr_ur_lj",  v_ur_lj,  e3);
    check("udr_ur_i2s", v_ur_i2s, e3);
    check("udr_fs_tdm", v_fs_tdm, e2);
    check("udr_ur_tdm", v_ur_tdm, e2);
    check("udr_ws_lj",  v_ws_lj,  256'({3{64'h00000000FFFFFFFF}}));

    // Fill the holding register mid-frame, then reset over it.
    collect(5);
    s_data_st  = {24'h123456, 24'h654321};
    s_valid_st = 1'b1;
    step();
    step();
    check("hold_full", 256'(ready_lj), 256'(0));
    rst = 1'b1;
    repeat (3) step();
    check_reset("reset_mid");
    rst = 1'b0;
    collect(1);
    check("rst_first_tick", 256'(last_wait), 256'(4));
    check("rst_discard_lj",  256'({fs_lj, ur_lj, sd_lj, ws_lj}), 256'(4'b1100));
    check("rst_discard_i2s", 256'({fs_i2s, ur_i2s, sd_i2s, ws_i2s}), 256'(4'b1100));
    check("rst_restart_tdm", 256'({fs_tdm, ur_tdm, ws_tdm}), 256'(3'b111));

    // Source always valid with a new payload after every transfer.
    st_stream  = 1'b1;
    pay        = 0;
    s_data_st  = st_word(0);
    s_valid_st = 1'b1;
    collect(63);
    for (int f = 0; f < 4; f++) begin
      collect(64);
      check($sformatf("bp_sd_lj_%0d", f),  v_sd_lj,  256'(st_frame(f)));
      check($sformatf("bp_sd_i2s_%0d", f), v_sd_i2s, 256'(st_frame(f) >> 1));
      check($sformatf("bp_fs_%0d", f),     v_fs_lj,  256'(64'h8000000000000000));
      check($sformatf("bp_ur_%0d", f),     v_ur_lj,  256'(0));
    end
    s_valid_st = 1'b0;
    st_stream  = 1'b0;
    check("bp_xfer_count", 256'(pay), 256'(5));

    check("ready_protocol", 256'(rdy_bad), 256'(0));
    check("bck_period", 256'(period_bad), 256'(0));
    check("stable_between_ticks", 256'(stable_bad), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
